// File: rtl/tl_c_pkg.sv
// Shared TileLink channel C/D definitions for the dcache release sink.
package tl_c_pkg;

    localparam logic [2:0] C_PROBE_ACK      = 3'd4;
    localparam logic [2:0] C_PROBE_ACK_DATA = 3'd5;
    localparam logic [2:0] C_RELEASE        = 3'd6;
    localparam logic [2:0] C_RELEASE_DATA   = 3'd7;
    localparam logic [2:0] D_RELEASE_ACK    = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ACK
    } state_e;

    // Number of DATA_W beats needed to carry 2^lg_size bytes.
    function automatic int unsigned beat_count(input int unsigned lg_size,
                                               input int unsigned lg_beat);
        return (lg_size <= lg_beat) ? 32'd1 : (32'd1 << (lg_size - lg_beat));
    endfunction

endpackage

// File: rtl/tl_c_release_sink.sv
// Channel C sink: streams data beats to the writeback path with no buffering,
// answers Release/ReleaseData with ReleaseAck on D, and signals probe completion.
module tl_c_release_sink
    import tl_c_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 32,
    parameter int SOURCE_W    = 4,
    parameter int SIZE_W      = 4,
    parameter int PROT_W      = 3,
    parameter int MAX_LG_SIZE = 6
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                c_valid,
    output logic                c_ready,
    input  logic [2:0]          c_opcode,
    input  logic [2:0]          c_param,
    input  logic [SIZE_W-1:0]   c_size,
    input  logic [SOURCE_W-1:0] c_source,
    input  logic [ADDR_W-1:0]   c_address,
    input  logic [DATA_W-1:0]   c_data,
    input  logic [PROT_W-1:0]   c_echo_prot,

    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [SIZE_W-1:0]   d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic [PROT_W-1:0]   d_echo_prot,

    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [ADDR_W-1:0]   wb_address,
    output logic [DATA_W-1:0]   wb_data,
    output logic                wb_last,

    output logic                probe_done,
    output logic [2:0]          probe_param,
    output logic                protocol_err
);

    localparam int LG_BEAT = $clog2(DATA_W / 8);
    localparam int CNT_W   = (MAX_LG_SIZE > LG_BEAT) ? (MAX_LG_SIZE - LG_BEAT) : 1;

    state_e              state_q;
    logic                active_q;
    logic [2:0]          opcode_q;
    logic [2:0]          param_q;
    logic [SIZE_W-1:0]   size_q;
    logic [SOURCE_W-1:0] source_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [PROT_W-1:0]   prot_q;
    logic [CNT_W-1:0]    idx_q;
    logic [CNT_W-1:0]    last_q;
    logic                probe_done_q;
    logic [2:0]          probe_param_q;
    logic                err_q;

    logic                hdr_is_data;
    logic                hdr_is_release;
    logic                hdr_bad_op;
    logic                hdr_bad_size;
    logic [SIZE_W-1:0]   hdr_size;
    logic [CNT_W-1:0]    hdr_last;
    logic                q_is_release;
    logic                c_fire;

    // Header decode; oversized transfers are clamped to a full line.
    always_comb begin
        hdr_bad_op     = (c_opcode < C_PROBE_ACK);
        hdr_is_data    = (c_opcode == C_PROBE_ACK_DATA) || (c_opcode == C_RELEASE_DATA);
        hdr_is_release = (c_opcode == C_RELEASE) || (c_opcode == C_RELEASE_DATA);
        hdr_bad_size   = (32'(c_size) > 32'(MAX_LG_SIZE));
        hdr_size       = hdr_bad_size ? SIZE_W'(MAX_LG_SIZE) : c_size;
        hdr_last       = '0;
        if (hdr_is_data)
            hdr_last = CNT_W'(beat_count(32'(hdr_size), LG_BEAT) - 32'd1);
        q_is_release   = (opcode_q == C_RELEASE) || (opcode_q == C_RELEASE_DATA);
    end

    // Data beats pass straight through, so wb_ready is the C-side flow control.
    // active_q keeps c_ready low while reset is held and until the first clock after it.
    always_comb begin
        c_ready  = 1'b0;
        wb_valid = 1'b0;
        if (active_q) begin
            case (state_q)
                IDLE: begin
                    if (hdr_is_data) begin
                        c_ready  = wb_ready;
                        wb_valid = c_valid;
                    end else begin
                        c_ready  = 1'b1;
                    end
                end
                DATA: begin
                    c_ready  = wb_ready;
                    wb_valid = c_valid;
                end
                default: ;
            endcase
        end
        c_fire = c_valid && c_ready;
    end

    always_comb begin
        wb_data = c_data;
        if (state_q == DATA) begin
            wb_address = addr_q + (ADDR_W'(idx_q) << LG_BEAT);
            wb_last    = (idx_q == last_q);
        end else begin
            wb_address = c_address;
            wb_last    = (hdr_last == '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            active_q      <= 1'b0;
            opcode_q      <= '0;
            param_q       <= '0;
            size_q        <= '0;
            source_q      <= '0;
            addr_q        <= '0;
            prot_q        <= '0;
            idx_q         <= '0;
            last_q        <= '0;
            probe_done_q  <= 1'b0;
            probe_param_q <= '0;
            err_q         <= 1'b0;
        end else begin
            active_q     <= 1'b1;
            probe_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (c_fire) begin
                        opcode_q <= c_opcode;
                        param_q  <= c_param;
                        size_q   <= hdr_size;
                        source_q <= c_source;
                        addr_q   <= c_address;
                        prot_q   <= c_echo_prot;
                        last_q   <= hdr_last;
                        idx_q    <= CNT_W'(1);
                        if (hdr_bad_op || hdr_bad_size)
                            err_q <= 1'b1;
                        // Unknown opcodes are swallowed without any response.
                        if (hdr_bad_op) begin
                            state_q <= IDLE;
                        end else if (hdr_last != '0) begin
                            state_q <= DATA;
                        end else if (hdr_is_release) begin
                            state_q <= ACK;
                        end else begin
                            probe_done_q  <= 1'b1;
                            probe_param_q <= c_param;
                        end
                    end
                end
                DATA: begin
                    if (c_fire) begin
                        idx_q <= idx_q + CNT_W'(1);
                        if (idx_q == last_q) begin
                            if (q_is_release) begin
                                state_q <= ACK;
                            end else begin
                                state_q       <= IDLE;
                                probe_done_q  <= 1'b1;
                                probe_param_q <= param_q;
                            end
                        end
                    end
                end
                ACK: begin
                    if (d_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        d_valid      = (state_q == ACK);
        d_opcode     = d_valid ? D_RELEASE_ACK : 3'd0;
        d_param      = 2'd0;
        d_size       = size_q;
        d_source     = source_q;
        d_echo_prot  = prot_q;
        probe_done   = probe_done_q;
        probe_param  = probe_param_q;
        protocol_err = err_q;
    end

endmodule
